// File: rtl/logic_unit_arbiter_pkg.sv
// Shared types for the logic-unit arbiter slice.
//   op_e    : opcode encoding of the 4-operation logic unit
//   state_e : response-slot occupancy
package logic_unit_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOT = 2'b11
  } op_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/logic_unit_arbiter_if.sv
// Request/response bundle between the operand sources and the arbiter.
//   master : requester/consumer side (drives req_* valid/data, rsp_ready)
//   slave  : arbiter side (drives req_ready and the rsp_* slot)
// Requester i uses req_op[2i+1:2i], req_a/req_b[DATA_W*i +: DATA_W].
interface logic_unit_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8
);
  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [2*NUM_REQ-1:0]      req_op;
  logic [DATA_W*NUM_REQ-1:0] req_a;
  logic [DATA_W*NUM_REQ-1:0] req_b;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [DATA_W-1:0]         rsp_data;
  logic [ID_W-1:0]           rsp_id;
  logic [1:0]                rsp_op;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_op
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_op
  );

endinterface

// File: rtl/logic_unit_arbiter_4op.sv
// Combinational 4-operation logic unit.
//   a, b : operands (b ignored for OP_NOT)
//   op   : operation select
//   y    : bitwise result
module logic_unit_4op
  import logic_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  op_e               op,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    unique case (op)
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_NOT: y = ~a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic unit between NUM_REQ requesters,
// with a single-entry registered response slot tagged by requester id.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of logic_unit_arbiter_if (request and response ports)
module logic_unit_arbiter
  import logic_unit_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  logic_unit_arbiter_if.slave  bus
);

  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef struct packed {
    logic            found;
    logic [ID_W-1:0] idx;
  } pick_t;

  // First valid requester scanning ptr, ptr+1, ... modulo NUM_REQ.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] valid,
                                    input logic [ID_W-1:0]    ptr);
    pick_t       p;
    int unsigned idx;
    p = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr) + k) % NUM_REQ;
      if (!p.found && valid[ID_W'(idx)]) begin
        p.found = 1'b1;
        p.idx   = ID_W'(idx);
      end
    end
    return p;
  endfunction

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr;
  logic [DATA_W-1:0] rsp_data_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [1:0]        rsp_op_q;

  pick_t             pick;
  logic              can_accept;
  logic              transfer;
  op_e               sel_op;
  logic [DATA_W-1:0] sel_a, sel_b, alu_y;

  assign pick       = rr_pick(bus.req_valid, rr_ptr);
  assign can_accept = (state_q == EMPTY) | bus.rsp_ready;

  // rst_n gating keeps req_ready low for the whole reset assertion.
  always_comb begin
    bus.req_ready = '0;
    if (pick.found && can_accept && rst_n)
      bus.req_ready[pick.idx] = 1'b1;
  end

  assign transfer = |(bus.req_valid & bus.req_ready);

  assign sel_op = op_e'(bus.req_op[2*pick.idx +: 2]);
  assign sel_a  = bus.req_a[pick.idx*DATA_W +: DATA_W];
  assign sel_b  = bus.req_b[pick.idx*DATA_W +: DATA_W];

  logic_unit_4op #(.DATA_W(DATA_W)) u_op (
    .a  (sel_a),
    .b  (sel_b),
    .op (sel_op),
    .y  (alu_y)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (transfer) state_d = FULL;
      FULL:  if (bus.rsp_ready && !transfer) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
      rsp_op_q   <= '0;
    end else if (transfer) begin
      rr_ptr     <= (pick.idx == ID_W'(NUM_REQ - 1)) ? '0 : pick.idx + 1'b1;
      rsp_data_q <= alu_y;
      rsp_id_q   <= pick.idx;
      rsp_op_q   <= sel_op;
    end
  end

  assign bus.rsp_valid = (state_q == FULL);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_op    = rsp_op_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
module tb_logic_unit_arbiter;
  import logic_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks;
  int   errors;

  always #5 clk = ~clk;

  logic_unit_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

  logic_unit_arbiter #(.NUM_REQ(4), .DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.req_op[2*i +: 2] = op;
    bus.req_a[8*i +: 8]  = a;
    bus.req_b[8*i +: 8]  = b;
  endtask

  logic [7:0] sweep_exp [4];
  int         g;

  initial begin
    checks = 0;
    errors = 0;
    sweep_exp = '{8'h42, 8'hDB, 8'h99, 8'h3C};
    rst_n = 1'b0;
    bus.req_valid = 4'hF;
    bus.req_op = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b0;

    #12;
    check("rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_data",  32'(bus.rsp_data),  32'd0);
    check("rst_id",    32'(bus.rsp_id),    32'd0);
    check("rst_op",    32'(bus.rsp_op),    32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    bus.req_valid = '0;
    rst_n = 1'b1;

    // Fairness: all valid, each returns its own one-hot pattern via OR.
    for (int i = 0; i < 4; i++) set_req(i, OP_OR, 8'h01 << i, 8'h00);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'hF;
    #1;
    for (int n = 0; n < 6; n++) begin
      g = n % 4;
      check("rr_ready", 32'(bus.req_ready), 32'(4'b0001 << g));
      step();
      check("rr_valid", 32'(bus.rsp_valid), 32'd1);
      check("rr_id",    32'(bus.rsp_id),    32'(g));
      check("rr_data",  32'(bus.rsp_data),  32'(8'h01 << g));
    end

    // Backpressure: slot holds id 1 / data 02.
    bus.rsp_ready = 1'b0;
    #1;
    for (int n = 0; n < 5; n++) begin
      check("bp_ready", 32'(bus.req_ready), 32'd0);
      check("bp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_data",  32'(bus.rsp_data),  32'h02);
      check("bp_id",    32'(bus.rsp_id),    32'd1);
      step();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_resume_ready", 32'(bus.req_ready), 32'b0100);
    step();
    check("bp_resume_id",   32'(bus.rsp_id),   32'd2);
    check("bp_resume_data", 32'(bus.rsp_data), 32'h04);

    // Drain to empty, then confirm EMPTY accepts without rsp_ready.
    bus.req_valid = '0;
    step();
    check("drain_valid", 32'(bus.rsp_valid), 32'd0);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0001;
    #1;
    check("empty_ready", 32'(bus.req_ready), 32'b0001);
    bus.rsp_ready = 1'b1;
    step();
    check("skip_first_id", 32'(bus.rsp_id), 32'd0);

    // Pointer skip: ptr=1, only 0 and 3 valid -> 3 then 0.
    bus.req_valid = 4'b1001;
    #1;
    check("skip_ready3", 32'(bus.req_ready), 32'b1000);
    step();
    check("skip_id3",   32'(bus.rsp_id),   32'd3);
    check("skip_data3", 32'(bus.rsp_data), 32'h08);
    check("skip_ready0", 32'(bus.req_ready), 32'b0001);
    step();
    check("skip_id0",   32'(bus.rsp_id),   32'd0);
    check("skip_data0", 32'(bus.rsp_data), 32'h01);

    // Single op sweep on requester 2.
    bus.req_valid = 4'b0100;
    for (int op = 0; op < 4; op++) begin
      set_req(2, 2'(op), 8'hC3, 8'h5A);
      #1;
      check("sweep_ready", 32'(bus.req_ready), 32'b0100);
      step();
      check("sweep_valid", 32'(bus.rsp_valid), 32'd1);
      check("sweep_data",  32'(bus.rsp_data),  32'(sweep_exp[op]));
      check("sweep_id",    32'(bus.rsp_id),    32'd2);
      check("sweep_op",    32'(bus.rsp_op),    32'(op));
    end
    bus.req_valid = '0;
    step();
    check("drain2_valid", 32'(bus.rsp_valid), 32'd0);

    // Async reset while FULL.
    bus.req_valid = 4'hF;
    #1;
    step();
    check("ar_full", 32'(bus.rsp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(bus.rsp_valid), 32'd0);
    check("ar_ready", 32'(bus.req_ready), 32'd0);
    #3;
    rst_n = 1'b1;
    #1;
    check("ar_first_ready", 32'(bus.req_ready), 32'b0001);
    step();
    check("ar_first_id",    32'(bus.rsp_id),    32'd0);
    check("ar_first_valid", 32'(bus.rsp_valid), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
Shares one 4-operation logic unit (AND, OR, XOR, NOT) between NUM_REQ requesters. Each requester offers an opcode and two operands over a valid/ready handshake. A round-robin arbiter picks one request per cycle, the selected operation is computed, and the result is registered into a single-entry response slot tagged with the requester id. The block sits between the lab datapath's operand sources and the 4:1 op-select logic, which it replaces as the only driver of the op select.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, operand and result width in bits
ID_W, $clog2(NUM_REQ), derived localparam, requester id width

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
req_op  in  2*NUM_REQ  packed opcodes; requester i uses bits [2i+1:2i]
req_a  in  DATA_W*NUM_REQ  packed operand A
req_b  in  DATA_W*NUM_REQ  packed operand B
rsp_valid  out  1  response slot holds a result
rsp_ready  in  1  consumer accepts the response
rsp_data  out  DATA_W  result
rsp_id  out  ID_W  index of the requester that produced the result
rsp_op  out  2  opcode that produced the result

Behaviour:
- Reset (async assert, sync release): rsp_valid=0, rsp_data=0, rsp_id=0, rsp_op=0, rr_ptr=0, state=EMPTY. req_ready=0 while rst_n=0.
- Opcode: 00 = a&b, 01 = a|b, 10 = a^b, 11 = ~a (b ignored). All are bitwise over DATA_W.
- can_accept = (state==EMPTY) | rsp_ready.
- Grant: the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ. req_ready[i] = grant[i] & can_accept, and is combinational.
- Transfer: occurs when req_valid[i] & req_ready[i]. At that clk edge, rsp_data, rsp_id and rsp_op load, and rr_ptr becomes (i+1) mod NUM_REQ.
- Latency: a request accepted in cycle N gives rsp_valid=1 in cycle N+1.
- The grant may move to another requester before a transfer if valids change. There is no lock. rr_ptr changes only on a transfer.
- FSM states and transitions:
  - EMPTY: on transfer, go to FULL; otherwise stay.
  - FULL, rsp_ready=0: stay. rsp_data, rsp_id and rsp_op must hold stable, and req_ready is all 0.
  - FULL, rsp_ready=1, transfer: stay FULL. The new result replaces the old one in the same edge, giving full throughput of one result per cycle.
  - FULL, rsp_ready=1, no transfer: go to EMPTY. rsp_data keeps its last value (don't-care).
- Simultaneous requests: exactly one is granted per cycle. The others wait, and each waits at most NUM_REQ-1 transfers (starvation-free).
- Reset mid-operation: a pending result is discarded, and the pointer returns to 0.
- Requester protocol: once req_valid is raised, op/a/b must hold until the transfer. The block does not check this.

Decomposition:
- Package logic_unit_pkg holds:
  - op_e enum: OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NOT=2'b11
  - state_e: EMPTY, FULL
- Sub-module logic_unit_4op is purely combinational. It takes a, b and op and returns y. It is instantiated once, fed by the granted requester's fields.
- The round-robin pick is a function inside the arbiter, not a separate module.

Test Plan:
- Single op sweep, NUM_REQ=4, DATA_W=8. Only req 2 valid, a=8'hC3, b=8'h5A, op 00/01/10/11 in turn, rsp_ready=1. Expect rsp_data 8'h42, 8'hDB, 8'h99, 8'h3C, each one cycle after its transfer, with rsp_id=2.
- Round-robin fairness: all 4 valid continuously, rsp_ready=1. Expect grants 0,1,2,3,0,1 on consecutive cycles, rsp_id following one cycle later, and no idle cycles.
- Backpressure: rsp_ready=0 for 5 cycles after the first result. Expect rsp_valid=1, rsp_data/rsp_id stable, and req_ready=0 throughout. When rsp_ready returns to 1, the next transfer occurs in the same cycle.
- Pointer skip: rr_ptr=1 after granting 0. Then only req 0 and req 3 are valid. Expect req 3 granted first, then req 0.
- Drain to empty: FULL with rsp_ready=1 and no valids. Expect rsp_valid to fall the next cycle and the state to be EMPTY.
- Async reset mid-stream: drop rst_n between clock edges while FULL. Expect rsp_valid=0 immediately and, after release, the first grant to be req 0 when all are valid.
